// File: rtl/bus_memory_slave.sv
// bus_memory_slave: word-addressed SRAM bus slave with request/ready handshake,
// byte write strobes, out-of-range error response and zero-fill sweep after reset.
module bus_memory_slave #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDR_WIDTH    = 8,
   parameter int DEPTH         = 32,
   parameter int INIT_ON_RESET = 1
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    s_sel,
   input  logic                    s_wr,
   input  logic [ADDR_WIDTH-1:0]   s_addr,
   input  logic [DATA_WIDTH-1:0]   s_wdata,
   input  logic [DATA_WIDTH/8-1:0] s_wstrb,
   output logic [DATA_WIDTH-1:0]   s_rdata,
   output logic                    s_ready,
   output logic                    s_err,
   output logic                    init_done
);
   localparam int NB = DATA_WIDTH / 8;
   localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   typedef enum logic [1:0] {INIT, IDLE, RESP} state_t;
   state_t state, state_nx;
   logic [IW-1:0] cnt, idx;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] rdata_nx;
   logic in_range, accept, last, ready_nx, err_nx, done_nx;
   assign idx = s_addr[IW-1:0];
   assign in_range = 32'(s_addr) < DEPTH;
   assign accept = state == IDLE && s_sel;
   assign last = cnt == IW'(DEPTH - 1);
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state <= INIT_ON_RESET != 0 ? INIT : IDLE;
         cnt <= '0;
         s_ready <= 1'b0;
         s_err <= 1'b0;
         s_rdata <= '0;
         init_done <= INIT_ON_RESET == 0;
      end else begin
         state <= state_nx;
         cnt <= state == INIT ? cnt + 1'b1 : '0;
         s_ready <= ready_nx;
         s_err <= err_nx;
         s_rdata <= rdata_nx;
         init_done <= done_nx;
      end
   always_comb
      state_nx = state == INIT ? (last ? IDLE : INIT) :
                 state == IDLE ? (s_sel ? RESP : IDLE) : IDLE;
   always_comb begin
      ready_nx = accept;
      err_nx = accept && !in_range;
      rdata_nx = accept && !s_wr ? (in_range ? mem[idx] : '0) : s_rdata;
      done_nx = init_done || (state == INIT && last);
   end
   // array has no reset; the write path is gated so nothing lands while reset is held
   always_ff @(posedge clk)
      if (state == INIT)
         mem[cnt] <= '0;
      else if (reset_n && accept && s_wr && in_range)
         for (int b = 0; b < NB; b++)
            if (s_wstrb[b]) mem[idx][8*b +: 8] <= s_wdata[8*b +: 8];
endmodule

// File: tb/tb_bus_memory_slave.sv
// tb_bus_memory_slave: directed vectors for bus_memory_slave (defaults: 32-bit data, DEPTH 32).
module tb_bus_memory_slave;
   logic clk = 1'b0, reset_n = 1'b0, s_sel = 1'b0, s_wr = 1'b0;
   logic [7:0] s_addr = '0;
   logic [31:0] s_wdata = '0;
   logic [3:0] s_wstrb = '0;
   logic [31:0] s_rdata;
   logic s_ready, s_err, init_done;
   int vectors = 0, miscompares = 0;
   always #5 clk = ~clk;
   bus_memory_slave dut (
      .clk(clk), .reset_n(reset_n), .s_sel(s_sel), .s_wr(s_wr), .s_addr(s_addr),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_rdata(s_rdata), .s_ready(s_ready),
      .s_err(s_err), .init_done(init_done)
   );
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask
   // called on a negedge; returns on the negedge where the next request may be driven
   task automatic access(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, output logic err, output logic [31:0] rdata);
      s_sel = 1'b1;
      s_wr = wr;
      s_addr = addr;
      s_wdata = wdata;
      s_wstrb = wstrb;
      @(posedge clk);
      @(negedge clk);
      check("ready_high", 32'(s_ready), 1);
      err = s_err;
      rdata = s_rdata;
      s_sel = 1'b0;
      @(negedge clk);
      check("ready_one_cycle", 32'(s_ready), 0);
      check("err_clears", 32'(s_err), 0);
   endtask
   task automatic wait_init(input string tag);
      int n = 0;
      logic seen = 1'b0;
      while (!init_done && n < 100) begin
         @(posedge clk);
         #1;
         n++;
         seen |= s_ready;
      end
      check(tag, n, 32);
      check({tag, "_no_ready"}, 32'(seen), 0);
   endtask
   initial begin
      logic e;
      logic [31:0] d;
      repeat (2) @(negedge clk);
      check("rst_ready", 32'(s_ready), 0);
      check("rst_err", 32'(s_err), 0);
      check("rst_rdata", s_rdata, 0);
      check("rst_init_done", 32'(init_done), 0);
      reset_n = 1'b1;
      wait_init("init_cycles");
      @(negedge clk);
      for (int k = 0; k < 32; k++) begin
         access(1'b0, 8'(k), '0, '0, e, d);
         check("zero_data", d, 0);
         check("zero_err", 32'(e), 0);
      end
      for (int k = 0; k < 32; k++) begin
         access(1'b1, 8'(k), 32'(k + 1), 4'hF, e, d);
         check("wr_err", 32'(e), 0);
      end
      for (int k = 0; k < 32; k++) begin
         access(1'b0, 8'(k), '0, '0, e, d);
         check("rd_data", d, 32'(k + 1));
         check("rd_err", 32'(e), 0);
      end
      access(1'b0, 8'h20, '0, '0, e, d);
      check("oor_rd_err", 32'(e), 1);
      check("oor_rd_data", d, 0);
      access(1'b0, 8'd31, '0, '0, e, d);
      check("pre_oor_wr", d, 32);
      access(1'b1, 8'hFF, 32'hDEADBEEF, 4'hF, e, d);
      check("oor_wr_err", 32'(e), 1);
      check("oor_wr_holds_rdata", d, 32);
      access(1'b0, 8'd0, '0, '0, e, d);
      check("post_oor_err", 32'(e), 0);
      check("post_oor_data", d, 1);
      access(1'b1, 8'd5, 32'h11223344, 4'hF, e, d);
      access(1'b1, 8'd5, 32'hAABBCCDD, 4'b0101, e, d);
      access(1'b0, 8'd5, '0, '0, e, d);
      check("strb_0101", d, 32'h11BB33DD);
      access(1'b1, 8'd5, 32'hFFFFFFFF, 4'b0000, e, d);
      check("strb_0_err", 32'(e), 0);
      access(1'b0, 8'd5, '0, '0, e, d);
      check("strb_0_keep", d, 32'h11BB33DD);
      s_sel = 1'b1;
      s_wr = 1'b0;
      s_addr = 8'd5;
      @(posedge clk);
      #1;
      check("pre_rst_ready", 32'(s_ready), 1);
      check("pre_rst_rdata", s_rdata, 32'h11BB33DD);
      #1 reset_n = 1'b0;
      #1;
      check("async_rst_ready", 32'(s_ready), 0);
      check("async_rst_rdata", s_rdata, 0);
      check("async_rst_err", 32'(s_err), 0);
      check("async_rst_init_done", 32'(init_done), 0);
      @(negedge clk);
      reset_n = 1'b1;
      wait_init("reinit_cycles");
      @(negedge clk);
      check("held_sel_not_yet", 32'(s_ready), 0);
      @(posedge clk);
      #1;
      check("held_sel_accepted", 32'(s_ready), 1);
      check("held_sel_data", s_rdata, 0);
      s_sel = 1'b0;
      @(negedge clk);
      check("drop_sel_in_resp", 32'(s_ready), 1);
      @(negedge clk);
      check("drop_sel_done", 32'(s_ready), 0);
      for (int k = 0; k < 32; k++) begin
         access(1'b0, 8'(k), '0, '0, e, d);
         check("rezero_data", d, 0);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
